// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle for the AES-128 inverse key scheduler: key load side and round-key stream.
// The master drives the load and consumer-ready; the slave is the scheduler itself.
interface aes_inv_key_sched_if;
  logic [127:0] key_in;
  logic         load;
  logic         ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  modport master (
    output key_in, load, rk_ready,
    input  ready, rk_out, rk_round, rk_valid, done
  );

  modport slave (
    input  key_in, load, rk_ready,
    output ready, rk_out, rk_round, rk_valid, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: emits K10..K0 by running the expansion backwards.
// Define AES_FWD_EXPAND_EN to load the cipher key K0 and expand forward to K10 internally first.
module aes_inv_key_sched (
  input logic                   clk,
  input logic                   rst,
  aes_inv_key_sched_if.slave    bus
);

  localparam logic [0:255][7:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SboxTbl[w[31:24]], SboxTbl[w[23:16]], SboxTbl[w[15:8]], SboxTbl[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

`ifdef AES_FWD_EXPAND_EN
  typedef enum logic [1:0] {StIdle, StEmit, StExpand} state_e;
`else
  typedef enum logic [0:0] {StIdle, StEmit} state_e;
`endif

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, sub_rot;
  logic [127:0] back_key;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];

  // One bank of four S-boxes: fed w3 while expanding forward, K_{r-1}.w3 when stepping back.
`ifdef AES_FWD_EXPAND_EN
  assign sub_in = (state_q == StExpand) ? w3 : (w3 ^ w2);
`else
  assign sub_in = w3 ^ w2;
`endif
  assign sub_rot = sub_word({sub_in[23:0], sub_in[31:24]}) ^ {rcon(round_q), 24'h0};

  assign back_key = {w0 ^ sub_rot, w1 ^ w0, w2 ^ w1, w3 ^ w2};

`ifdef AES_FWD_EXPAND_EN
  logic [31:0]  f0, f1, f2, f3;
  assign f0 = w0 ^ sub_rot;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
`endif

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          rk_d = bus.key_in;
`ifdef AES_FWD_EXPAND_EN
          round_d = 4'd1;
          state_d = StExpand;
`else
          round_d = 4'd10;
          state_d = StEmit;
`endif
        end
      end
      StEmit: begin
        if (bus.rk_ready) begin
          if (round_q != 4'd0) begin
            rk_d    = back_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
`ifdef AES_FWD_EXPAND_EN
      StExpand: begin
        rk_d = {f0, f1, f2, f3};
        // Round 10 is already the emit start index, so it is left in place.
        if (round_q == 4'd10) begin
          state_d = StEmit;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rk_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready    = (state_q == StIdle);
  assign bus.rk_valid = (state_q == StEmit);
  assign bus.rk_out   = rk_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: expected keys come from a forward key-expansion
// model built on an arithmetically derived S-box, then compared in reverse emission order.
module tb_aes_inv_key_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_key_sched_if bus ();

  aes_inv_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_kt [11];
  logic [127:0] fips_ref [11];
  bit           fips_known [11];

  localparam logic [127:0] FipsK0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box straight from its definition: multiplicative inverse then the affine map.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
               ^ inv[(i + 7) % 8] ^ c[i];
      sb[x] = s;
    end
    for (int r = 0; r < 11; r++) begin
      fips_ref[r] = '0;
      fips_known[r] = 1'b0;
    end
    fips_ref[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; fips_known[10] = 1'b1;
    fips_ref[9]  = 128'hac7766f319fadc2128d12941575c006e; fips_known[9]  = 1'b1;
    fips_ref[1]  = 128'ha0fafe1788542cb123a339392a6c7605; fips_known[1]  = 1'b1;
    fips_ref[0]  = FipsK0;                                 fips_known[0]  = 1'b1;
  endtask

  function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = tb_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_kt[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [127:0] k0, input string name);
    int n;
    model_expand(k0);
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_wait: ready=%b required 1 within 50 cycles", name, bus.ready);
    end
`ifdef AES_FWD_EXPAND_EN
    bus.key_in = k0;
`else
    bus.key_in = exp_kt[10];
`endif
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.key_in = rand_key();
`ifdef AES_FWD_EXPAND_EN
    n = 1;
    while (bus.rk_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 11) begin
      failures++;
      $display("FAIL %s expand_latency: rk_valid after %0d cycles, required 11", name, n);
    end
`endif
  endtask

  // Walks the emission from round 10 to 0; inject >= 0 pulses a stray load at that round.
  task automatic emit_seq(input bit rnd, input int inject, input bit fips, input string name);
    int idx;
    int cyc;
    bit fin;
    bit stall;
    bit hs;
    logic [127:0] prev;
    idx = 10;
    cyc = 0;
    fin = 1'b0;
    stall = 1'b0;
    prev = '0;
    while (!fin && cyc < 400) begin
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== idx[3:0] || bus.rk_out !== exp_kt[idx]) begin
        failures++;
        $display("FAIL %s key: valid=%b round=%0d rk_out=%h required valid=1 round=%0d rk_out=%h",
                 name, bus.rk_valid, bus.rk_round, bus.rk_out, idx, exp_kt[idx]);
      end
      if (stall) begin
        checks++;
        if (bus.rk_out !== prev) begin
          failures++;
          $display("FAIL %s stall_hold: rk_out=%h required %h", name, bus.rk_out, prev);
        end
      end
      if (fips && fips_known[idx]) begin
        checks++;
        if (bus.rk_out !== fips_ref[idx]) begin
          failures++;
          $display("FAIL %s fips_round%0d: rk_out=%h required %h",
                   name, idx, bus.rk_out, fips_ref[idx]);
        end
      end
      bus.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == inject) begin
        bus.load = 1'b1;
        bus.key_in = rand_key();
        inject = -1;
      end
      hs = bus.rk_ready;
      stall = !hs;
      prev = bus.rk_out;
      tick();
      bus.load = 1'b0;
      cyc++;
      if (hs) begin
        if (idx == 0) fin = 1'b1;
        else idx--;
      end
    end
    checks++;
    if (!fin || (!rnd && cyc != 11)) begin
      failures++;
      $display("FAIL %s length: finished=%b after %0d cycles, required 11 keys in %s",
               name, fin, cyc, rnd ? "under 400 cycles" : "11 cycles");
    end
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s done_cycle: done=%b ready=%b rk_valid=%b required 1 1 0",
               name, bus.done, bus.ready, bus.rk_valid);
    end
  endtask

  task automatic check_done_drop(input string name);
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s done_drop: done=%b ready=%b rk_valid=%b required 0 1 0",
               name, bus.done, bus.ready, bus.rk_valid);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (bus.rk_out !== '0 || bus.rk_round !== 4'd0 || bus.rk_valid !== 1'b0 ||
        bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s reset_values: rk_out=%h round=%0d valid=%b done=%b ready=%b required 0 0 0 0 1",
               name, bus.rk_out, bus.rk_round, bus.rk_valid, bus.done, bus.ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.load = 1'b0;
    bus.rk_ready = 1'b0;
    bus.key_in = '0;
    #2;
    check_cleared("reset");
    #1 rst = 1'b1;
    tick();
    check_cleared("post_reset_idle");
  endtask

  task automatic test_fips();
    start_seq(FipsK0, "fips");
    emit_seq(1'b0, -1, 1'b1, "fips");
    check_done_drop("fips");
  endtask

  task automatic test_backpressure();
    start_seq(FipsK0, "bp_fips");
    emit_seq(1'b1, -1, 1'b1, "bp_fips");
    check_done_drop("bp_fips");
    for (int i = 0; i < 3; i++) begin
      start_seq(rand_key(), "bp_rand");
      emit_seq(1'b1, -1, 1'b0, "bp_rand");
      check_done_drop("bp_rand");
    end
  endtask

  task automatic test_reset_mid();
    start_seq(FipsK0, "reset_mid");
    bus.rk_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd5 || bus.rk_out !== exp_kt[5]) begin
      failures++;
      $display("FAIL reset_mid at_round5: valid=%b round=%0d rk_out=%h required 1 5 %h",
               bus.rk_valid, bus.rk_round, bus.rk_out, exp_kt[5]);
    end
    #1 rst = 1'b0;
    #1 check_cleared("reset_mid");
    #1 rst = 1'b1;
    tick();
    start_seq(FipsK0, "reset_mid_reload");
    emit_seq(1'b0, -1, 1'b1, "reset_mid_reload");
    check_done_drop("reset_mid_reload");
  endtask

  task automatic test_load_ignored();
    start_seq(rand_key(), "load_ignored");
    emit_seq(1'b0, 7, 1'b0, "load_ignored");
    check_done_drop("load_ignored");
  endtask

  task automatic test_back_to_back();
    start_seq(rand_key(), "b2b_first");
    emit_seq(1'b0, -1, 1'b0, "b2b_first");
    // Still in the done cycle: the next load must be taken here.
    start_seq(rand_key(), "b2b_second");
    emit_seq(1'b0, -1, 1'b0, "b2b_second");
    check_done_drop("b2b_second");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_backpressure();
    test_reset_mid();
    test_load_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
